// File: rtl/cache_pkg.sv
// Shared types for the cache miss-side replacement controller.
// Holds the FSM state encoding, the way count and the one-hot way type.
package cache_pkg;

  localparam int WAYS = 4;

  typedef logic [WAYS-1:0] way_oh_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    UPD  = 2'd3
  } state_e;

  // Isolates the lowest set bit; yields zero for a zero input.
  function automatic way_oh_t lowest_set(input way_oh_t v);
    return v & (~v + way_oh_t'(1));
  endfunction

endpackage

// File: rtl/victim_pick.sv
// Combinational victim selection for one 4-way set.
// Invalid ways win over the LRU hint; a malformed LRU hint is reduced to one hot.
module victim_pick
  import cache_pkg::*;
(
  input  way_oh_t way_valid,
  input  way_oh_t lru_way,
  output way_oh_t victim
);

  way_oh_t invalid;

  assign invalid = ~way_valid;

  always_comb begin
    victim = '0;
    if (invalid != '0) begin
      victim = lowest_set(invalid);
    end else if (lru_way == '0) begin
      victim = way_oh_t'(1);
    end else begin
      victim = lowest_set(lru_way);
    end
  end

endmodule

// File: rtl/cache_victim_ctrl.sv
// Miss-side replacement controller: picks a victim, sequences writeback and
// fill, then strobes the LRU tracker with the filled way.
module cache_victim_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  logic [TAG_W-1:0]     miss_tag,
  input  way_oh_t              lru_way,
  input  way_oh_t              way_valid,
  input  way_oh_t              way_dirty,
  input  logic [4*TAG_W-1:0]   way_tags,
  output logic                 wb_req,
  input  logic                 wb_ack,
  output logic [TAG_W-1:0]     wb_tag,
  output logic                 fill_req,
  input  logic                 fill_ack,
  output logic [TAG_W-1:0]     fill_tag,
  output way_oh_t              lru_upd,
  output logic                 lru_upd_en,
  output logic                 done,
  output way_oh_t              done_way,
  output state_e               state_dbg
);

  // Handshakes: a miss transfers on the cycle miss_valid && miss_ready is
  // sampled; wb/fill requests hold until their own ack is sampled high, and an
  // ack seen while its request is low is ignored.

  state_e            state_q, state_d;
  way_oh_t           victim, victim_q;
  logic [TAG_W-1:0]  victim_tag, victim_tag_q, miss_tag_q;
  logic              victim_dirty;
  logic              accept;

  victim_pick u_pick (
    .way_valid (way_valid),
    .lru_way   (lru_way),
    .victim    (victim)
  );

  always_comb begin
    victim_tag = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (victim[i]) begin
        victim_tag = way_tags[i*TAG_W +: TAG_W];
      end
    end
  end

  assign victim_dirty = |(victim & way_valid & way_dirty);
  // Held low during reset so no miss is taken before the FSM is known-idle.
  assign miss_ready   = (state_q == IDLE) && !rst;
  assign accept       = miss_valid && miss_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)   state_d = victim_dirty ? WB : FILL;
      WB:   if (wb_ack)   state_d = FILL;
      FILL: if (fill_ack) state_d = UPD;
      UPD:                state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      victim_tag_q <= '0;
      miss_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        victim_q     <= victim;
        victim_tag_q <= victim_tag;
        miss_tag_q   <= miss_tag;
      end
    end
  end

  assign wb_req     = (state_q == WB);
  assign fill_req   = (state_q == FILL);
  assign wb_tag     = wb_req ? victim_tag_q : '0;
  assign fill_tag   = fill_req ? miss_tag_q : '0;
  assign done       = (state_q == UPD);
  assign lru_upd_en = done;
  assign lru_upd    = done ? victim_q : '0;
  assign done_way   = done ? victim_q : '0;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Bench for cache_victim_ctrl: directed scenarios plus randomized misses,
// checked by a queue-based scoreboard fed from a behavioural victim model.
module tb_cache_victim_ctrl;

  localparam int TAG_W = 20;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, miss_valid, wb_ack, fill_ack;
  logic [TAG_W-1:0]   miss_tag;
  logic [3:0]         lru_way, way_valid, way_dirty;
  logic [4*TAG_W-1:0] way_tags;
  logic               miss_ready, wb_req, fill_req, lru_upd_en, done;
  logic [TAG_W-1:0]   wb_tag, fill_tag;
  logic [3:0]         lru_upd, done_way;
  cache_pkg::state_e  state_dbg;

  cache_victim_ctrl #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .miss_valid (miss_valid),
    .miss_ready (miss_ready),
    .miss_tag   (miss_tag),
    .lru_way    (lru_way),
    .way_valid  (way_valid),
    .way_dirty  (way_dirty),
    .way_tags   (way_tags),
    .wb_req     (wb_req),
    .wb_ack     (wb_ack),
    .wb_tag     (wb_tag),
    .fill_req   (fill_req),
    .fill_ack   (fill_ack),
    .fill_tag   (fill_tag),
    .lru_upd    (lru_upd),
    .lru_upd_en (lru_upd_en),
    .done       (done),
    .done_way   (done_way),
    .state_dbg  (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [TAG_W-1:0] exp_wb_q[$];
  logic [TAG_W-1:0] exp_fill_q[$];
  logic [3:0]       exp_done_q[$];

  bit         mon_en = 1'b0;
  bit         trk_en = 1'b0;
  int         trk_q[$];
  logic       wb_prev = 1'b0, fill_prev = 1'b0;
  int         wb_run = 0, wb_len = 0;
  int         done_cyc_last = -1, done_cyc_prev = -1;
  logic [3:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference victim rule: first invalid way, else first LRU bit, else way 0.
  function automatic logic [3:0] model_victim(input logic [3:0] v, input logic [3:0] lru);
    for (int i = 0; i < 4; i++) if (!v[i]) return 4'(1 << i);
    for (int i = 0; i < 4; i++) if (lru[i]) return 4'(1 << i);
    return 4'b0001;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_req && !wb_prev) begin
        if (exp_wb_q.size() == 0) chk("wb_unexpected", 32'(wb_req), 0);
        else chk("wb_tag", 32'(wb_tag), 32'(exp_wb_q.pop_front()));
      end
      if (wb_req) wb_run++;
      else if (wb_prev) begin
        wb_len = wb_run;
        wb_run = 0;
      end
      if (fill_req && !fill_prev) begin
        if (exp_fill_q.size() == 0) chk("fill_unexpected", 32'(fill_req), 0);
        else chk("fill_tag", 32'(fill_tag), 32'(exp_fill_q.pop_front()));
      end
      if (done) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", 32'(done), 0);
        else begin
          mon_e = exp_done_q.pop_front();
          chk("done_way", 32'(done_way), 32'(mon_e));
          chk("lru_upd", 32'({lru_upd_en, lru_upd}), 32'({1'b1, mon_e}));
        end
        done_cyc_prev = done_cyc_last;
        done_cyc_last = cyc;
      end else begin
        chk("upd_gate", 32'({lru_upd_en, lru_upd, done_way}), 0);
      end
      if (trk_en && lru_upd_en) begin
        for (int i = 0; i < trk_q.size(); i++) begin
          if (lru_upd[trk_q[i]]) begin
            trk_q.push_back(trk_q[i]);
            trk_q.delete(i);
            break;
          end
        end
        lru_way = 4'(1 << trk_q[0]);
      end
      wb_prev   = wb_req;
      fill_prev = fill_req;
    end
  end

  // driver tasks
  task automatic serve(input bit is_wb, input int lat);
    int t = 0;
    while (!(is_wb ? wb_req : fill_req) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(is_wb ? "wb_req_seen" : "fill_req_seen", 32'(is_wb ? wb_req : fill_req), 1);
    repeat (lat) begin
      if (is_wb) fill_ack = 1'($urandom_range(0, 1));
      else       wb_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    wb_ack   = 1'b0;
    fill_ack = 1'b0;
    if (is_wb) wb_ack = 1'b1;
    else       fill_ack = 1'b1;
    @(negedge clk);
    wb_ack   = 1'b0;
    fill_ack = 1'b0;
  endtask

  task automatic do_miss(input logic [TAG_W-1:0] tag, input logic [3:0] v, input logic [3:0] d,
                         input logic [3:0] lru, input logic [4*TAG_W-1:0] tags,
                         input int wb_lat, input int fill_lat);
    logic [3:0] vic;
    int idx = 0;
    int t = 0;
    bit dirty;
    vic = model_victim(v, lru);
    for (int i = 0; i < 4; i++) if (vic[i]) idx = i;
    dirty = v[idx] && d[idx];
    if (dirty) exp_wb_q.push_back(tags[idx*TAG_W +: TAG_W]);
    exp_fill_q.push_back(tag);
    exp_done_q.push_back(vic);
    miss_valid = 1'b1;
    miss_tag   = tag;
    way_valid  = v;
    way_dirty  = d;
    lru_way    = lru;
    way_tags   = tags;
    while (!miss_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", 32'(miss_ready), 1);
    @(negedge clk);
    miss_valid = 1'b0;
    miss_tag   = TAG_W'($urandom);
    way_valid  = 4'($urandom);
    way_dirty  = 4'($urandom);
    lru_way    = 4'($urandom);
    way_tags   = 80'({$urandom, $urandom, $urandom});
    if (dirty) serve(1'b1, wb_lat);
    serve(1'b0, fill_lat);
  endtask

  function automatic logic [4*TAG_W-1:0] rand_tags();
    return 80'({$urandom, $urandom, $urandom});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [4*TAG_W-1:0] tg;

  initial begin
    rst = 1'b1; miss_valid = 1'b0; wb_ack = 1'b0; fill_ack = 1'b0;
    miss_tag = '0; lru_way = 4'b0001; way_valid = '0; way_dirty = '0; way_tags = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(miss_ready), 0);
    chk("rst_outs", 32'({wb_req, fill_req, done, lru_upd_en, lru_upd, done_way}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(miss_ready), 1);
    chk("post_rst_outs", 32'({wb_req, fill_req, done, lru_upd_en, lru_upd, done_way}), 0);
    chk("post_rst_tags", 32'(wb_tag | fill_tag), 0);
    mon_en = 1'b1;

    // clean miss into invalid way 2
    tg = rand_tags();
    exp_fill_q.push_back(20'h12345);
    exp_done_q.push_back(model_victim(4'b1011, 4'b0001));
    miss_valid = 1'b1; miss_tag = 20'h12345; way_valid = 4'b1011;
    way_dirty = 4'b1111; lru_way = 4'b0001; way_tags = tg;
    chk("t1_ready", 32'(miss_ready), 1);
    @(negedge clk);
    miss_valid = 1'b0;
    chk("t1_fill_req", 32'(fill_req), 1);
    chk("t1_no_wb", 32'(wb_req), 0);
    chk("t1_fill_tag", 32'(fill_tag), 32'h12345);
    fill_ack = 1'b1;
    @(negedge clk);
    fill_ack = 1'b0;
    chk("t1_done", 32'(done), 1);
    chk("t1_upd", 32'({lru_upd_en, lru_upd}), 32'h14);
    chk("t1_done_way", 32'(done_way), 32'h4);
    chk("t1_busy", 32'(miss_ready), 0);
    @(negedge clk);
    chk("t1_ready_back", 32'(miss_ready), 1);
    chk("t1_done_off", 32'(done), 0);

    // dirty eviction of way 3, wb_ack after 3 request cycles
    tg = rand_tags();
    tg[3*TAG_W +: TAG_W] = 20'h0ABCD;
    do_miss(TAG_W'($urandom), 4'hF, 4'b1000, 4'b1000, tg, 2, 1);
    chk("t2_wb_hold", 32'(wb_len), 3);

    // non-one-hot and empty LRU hints
    do_miss(TAG_W'($urandom), 4'hF, 4'h0, 4'b0110, rand_tags(), 0, 0);
    do_miss(TAG_W'($urandom), 4'hF, 4'h0, 4'b0000, rand_tags(), 0, 1);

    // randomized misses
    for (int n = 0; n < 30; n++) begin
      do_miss(TAG_W'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), rand_tags(),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // stale fill_ack during WB, held miss_valid while busy
    @(negedge clk);
    tg = rand_tags();
    tg[TAG_W-1:0] = 20'h11111;
    exp_wb_q.push_back(20'h11111);
    exp_fill_q.push_back(20'hAAAAA);
    exp_done_q.push_back(model_victim(4'hF, 4'b0001));
    miss_valid = 1'b1; miss_tag = 20'hAAAAA; way_valid = 4'hF;
    way_dirty = 4'b0001; lru_way = 4'b0001; way_tags = tg;
    @(negedge clk);
    chk("t4_wb", 32'(wb_req), 1);
    chk("t4_ready_wb", 32'(miss_ready), 0);
    fill_ack = 1'b1;
    miss_tag = 20'h33333; way_valid = 4'b0111; way_dirty = 4'hF; way_tags = rand_tags();
    exp_fill_q.push_back(20'h33333);
    exp_done_q.push_back(model_victim(4'b0111, 4'b0001));
    @(negedge clk);
    chk("t4_stale", 32'(wb_req), 1);
    chk("t4_stale_fill", 32'(fill_req), 0);
    fill_ack = 1'b0;
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    chk("t4_fill", 32'(fill_req), 1);
    chk("t4_hold_ready", 32'(miss_ready), 0);
    @(negedge clk);
    chk("t4_fill_hold", 32'(fill_req), 1);
    fill_ack = 1'b1;
    @(negedge clk);
    fill_ack = 1'b0;
    chk("t4_done", 32'(done), 1);
    chk("t4_done_ready", 32'(miss_ready), 0);
    @(negedge clk);
    chk("t4_ready", 32'(miss_ready), 1);
    @(negedge clk);
    miss_valid = 1'b0;
    chk("t4_b_fill", 32'(fill_req), 1);
    chk("t4_b_no_wb", 32'(wb_req), 0);
    fill_ack = 1'b1;
    @(negedge clk);
    fill_ack = 1'b0;
    chk("t4_b_done", 32'(done), 1);

    // reset in the middle of FILL
    @(negedge clk);
    exp_fill_q.push_back(20'h5A5A5);
    miss_valid = 1'b1; miss_tag = 20'h5A5A5; way_valid = 4'h0; way_dirty = 4'h0;
    lru_way = 4'b0100; way_tags = rand_tags();
    @(negedge clk);
    miss_valid = 1'b0;
    chk("t5_fill", 32'(fill_req), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", 32'(miss_ready), 0);
    @(negedge clk);
    chk("t5_fill_drop", 32'(fill_req), 0);
    chk("t5_no_done", 32'({done, lru_upd_en}), 0);
    rst = 1'b0;
    #1;
    chk("t5_ready", 32'(miss_ready), 1);
    @(negedge clk);
    chk("t5_no_done2", 32'({done, lru_upd_en, fill_req}), 0);

    // back-to-back clean misses with a live LRU tracker
    trk_q = '{0, 1, 2, 3};
    lru_way = 4'b0001; way_valid = 4'hF; way_dirty = 4'h0; way_tags = rand_tags();
    trk_en = 1'b1;
    exp_fill_q.push_back(20'hB0001);
    exp_done_q.push_back(4'b0001);
    exp_fill_q.push_back(20'hB0002);
    exp_done_q.push_back(model_victim(4'hF, 4'b0010));
    miss_valid = 1'b1; miss_tag = 20'hB0001;
    @(negedge clk);
    chk("t6_fill_a", 32'(fill_req), 1);
    fill_ack = 1'b1;
    miss_tag = 20'hB0002;
    @(negedge clk);
    fill_ack = 1'b0;
    chk("t6_done_a", 32'(done), 1);
    @(negedge clk);
    chk("t6_ready", 32'(miss_ready), 1);
    @(negedge clk);
    miss_valid = 1'b0;
    chk("t6_fill_b", 32'(fill_req), 1);
    fill_ack = 1'b1;
    @(negedge clk);
    fill_ack = 1'b0;
    chk("t6_done_b", 32'(done), 1);
    @(negedge clk);
    chk("t6_gap", 32'(done_cyc_last - done_cyc_prev), 3);
    trk_en = 1'b0;

    // drain and report
    repeat (3) @(negedge clk);
    chk("left_wb", 32'(exp_wb_q.size()), 0);
    chk("left_fill", 32'(exp_fill_q.size()), 0);
    chk("left_done", 32'(exp_done_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
